// File: rtl/hz_pkg.sv
// Shared encodings and shadow-stage record for the pipeline hazard controller.
package hz_pkg;

    localparam int HZ_REG_W = 5;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_STALL    = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] dst;
        logic [HZ_REG_W-1:0] rs;
        logic [HZ_REG_W-1:0] rt;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
    } stage_t;

    // A bubble or a write to $0 never produces a value worth forwarding or waiting on.
    function automatic logic is_writer(stage_t s);
        return s.valid && s.reg_write && (s.dst != '0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID decode fields and status in, enables/flushes/selects out.
interface hazard_ctrl_if #(parameter int REG_W = hz_pkg::HZ_REG_W);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_regWrite;
    logic             id_memRead;
    logic             id_memWrite;
    logic             id_jump;
    logic             id_jr;
    logic             ex_branch_taken;
    logic             mem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       state;
    logic             mem_err;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
               id_regWrite, id_memRead, id_memWrite, id_jump, id_jr,
               ex_branch_taken, mem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, state, mem_err
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
               id_regWrite, id_memRead, id_memWrite, id_jump, id_jr,
               ex_branch_taken, mem_ready,
        output pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, state, mem_err
    );
endinterface

// File: rtl/fwd_unit.sv
// EX operand source select for one register index; the younger MEM result wins over WB.
module fwd_unit
    import hz_pkg::*;
(
    input  logic [HZ_REG_W-1:0] src,
    input  logic                mem_wr,
    input  logic [HZ_REG_W-1:0] mem_dst,
    input  logic                wb_wr,
    input  logic [HZ_REG_W-1:0] wb_dst,
    output logic [1:0]          sel
);

    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (mem_wr && (mem_dst == src)) begin
                sel = FWD_MEM;
            end else if (wb_wr && (wb_dst == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward sequencing for the 5-stage MIPS pipeline, tracking EX/MEM/WB in shadow registers.
//
// state       | meaning
// ST_RUN      | normal issue
// ST_STALL    | previous cycle held PC and IF/ID for a load-use or jr hazard
// ST_MEM_WAIT | previous cycle froze the pipe waiting on data memory
module hazard_ctrl
    import hz_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hz
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    stage_t           ex_q, mem_q, wb_q, id_rec;
    logic [1:0]       state_q, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_err_q;
    logic             ex_wr, mem_wr, wb_wr;
    logic             mem_wait, branch, hz_load, hz_jr, stall, jump;

    always_comb begin
        id_rec           = '0;
        id_rec.valid     = 1'b1;
        id_rec.dst       = hz.id_dst;
        id_rec.rs        = hz.id_rs;
        id_rec.rt        = hz.id_rt;
        id_rec.reg_write = hz.id_regWrite;
        id_rec.mem_read  = hz.id_memRead;
        id_rec.mem_write = hz.id_memWrite;
    end

    assign ex_wr  = is_writer(ex_q);
    assign mem_wr = is_writer(mem_q);
    assign wb_wr  = is_writer(wb_q);

    assign mem_wait = mem_q.valid && (mem_q.mem_read || mem_q.mem_write) && !hz.mem_ready;
    assign branch   = !mem_wait && hz.ex_branch_taken;
    assign hz_load  = ex_wr && ex_q.mem_read &&
                      ((hz.id_uses_rs && (ex_q.dst == hz.id_rs)) ||
                       (hz.id_uses_rt && (ex_q.dst == hz.id_rt)));
    // jr reads rs in ID, so any in-flight producer of rs must retire to WB first.
    assign hz_jr    = hz.id_jr &&
                      ((ex_wr && (ex_q.dst == hz.id_rs)) || (mem_wr && (mem_q.dst == hz.id_rs)));
    assign stall    = hz.id_valid && !mem_wait && !branch && (hz_load || hz_jr);
    assign jump     = hz.id_valid && !mem_wait && !branch && !stall && (hz.id_jump || hz.id_jr);

    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.idex_write  = 1'b1;
        hz.exmem_write = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.memwb_flush = 1'b0;
        if (mem_wait) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.memwb_flush = 1'b1;
        end else if (branch) begin
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else if (stall) begin
            hz.pc_write   = 1'b0;
            hz.ifid_write = 1'b0;
            hz.idex_flush = 1'b1;
        end else if (jump) begin
            hz.ifid_flush = 1'b1;
        end
    end

    fwd_unit u_fwd_a (
        .src     (ex_q.rs),
        .mem_wr  (mem_wr),
        .mem_dst (mem_q.dst),
        .wb_wr   (wb_wr),
        .wb_dst  (wb_q.dst),
        .sel     (hz.fwd_a)
    );

    fwd_unit u_fwd_b (
        .src     (ex_q.rt),
        .mem_wr  (mem_wr),
        .mem_dst (mem_q.dst),
        .wb_wr   (wb_wr),
        .wb_dst  (wb_q.dst),
        .sel     (hz.fwd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (mem_wait) begin
            wb_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (hz.id_valid && !branch && !stall) begin
                ex_q <= id_rec;
            end else begin
                ex_q <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (mem_wait) begin
            state_nxt = ST_MEM_WAIT;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: state_nxt = stall ? ST_STALL : ST_RUN;
                default:          state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // wait_cnt counts consecutive frozen cycles; mem_err sets on the MEM_TIMEOUT-th one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else if (mem_wait) begin
            if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_cnt >= (CNT_MAX - 1'b1)) begin
                mem_err_q <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    assign hz.state   = state_q;
    assign hz.mem_err = mem_err_q;

    logic unused_fields;
    assign unused_fields = ^{ex_q.mem_write, mem_q.rs, mem_q.rt,
                             wb_q.rs, wb_q.rt, wb_q.mem_read, wb_q.mem_write};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, forwarding, branch priority, jr, memory wait/timeout, async reset.
module tb_hazard_ctrl;
    import hz_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errs   = 0;
    int   checks = 0;

    hazard_ctrl_if hz_bus ();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                         input logic urs, input logic urt, input logic rw, input logic mr,
                         input logic mw, input logic j, input logic jr);
        hz_bus.id_valid    = v;
        hz_bus.id_rs       = rs;
        hz_bus.id_rt       = rt;
        hz_bus.id_dst      = dst;
        hz_bus.id_uses_rs  = urs;
        hz_bus.id_uses_rt  = urt;
        hz_bus.id_regWrite = rw;
        hz_bus.id_memRead  = mr;
        hz_bus.id_memWrite = mw;
        hz_bus.id_jump     = j;
        hz_bus.id_jr       = jr;
    endtask

    task automatic id_nop();                                    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic id_alu(input logic [4:0] d, s, t);           drive(1, s, t, d, 1, 1, 1, 0, 0, 0, 0); endtask
    task automatic id_lw(input logic [4:0] d, s);               drive(1, s, d, d, 1, 0, 1, 1, 0, 0, 0); endtask
    task automatic id_sw(input logic [4:0] s, t);               drive(1, s, t, 0, 1, 1, 0, 0, 1, 0, 0); endtask
    task automatic id_jr(input logic [4:0] s);                  drive(1, s, 0, 0, 1, 0, 0, 0, 0, 0, 1); endtask

    function automatic logic [3:0] en();
        return {hz_bus.pc_write, hz_bus.ifid_write, hz_bus.idex_write, hz_bus.exmem_write};
    endfunction

    function automatic logic [2:0] fl();
        return {hz_bus.ifid_flush, hz_bus.idex_flush, hz_bus.memwb_flush};
    endfunction

    initial begin
        id_nop();
        hz_bus.ex_branch_taken = 1'b0;
        hz_bus.mem_ready       = 1'b1;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_en", en(), 4'b1111);
        chk("rst_fl", fl(), 3'b000);
        chk("rst_fwd", {hz_bus.fwd_a, hz_bus.fwd_b}, 4'b0000);
        chk("rst_state", hz_bus.state, ST_RUN);
        chk("rst_err", hz_bus.mem_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // load-use: lw $8 then add reading $8
        id_lw(8, 1);
        tick();
        id_alu(9, 8, 2);
        #1;
        chk("lu_en", en(), 4'b0011);
        chk("lu_fl", fl(), 3'b010);
        chk("lu_state0", hz_bus.state, ST_RUN);
        tick();
        chk("lu_state1", hz_bus.state, ST_STALL);
        chk("lu_en1", en(), 4'b1111);
        chk("lu_fl1", fl(), 3'b000);
        tick();
        chk("lu_state2", hz_bus.state, ST_RUN);
        chk("lu_fwd_a", hz_bus.fwd_a, FWD_WB);
        chk("lu_fwd_b", hz_bus.fwd_b, FWD_RF);

        // forwarding: MEM=$7, WB=$3
        id_alu(3, 0, 0); tick();
        id_alu(7, 0, 0); tick();
        id_alu(10, 7, 3); tick();
        chk("fw_mix_a", hz_bus.fwd_a, FWD_MEM);
        chk("fw_mix_b", hz_bus.fwd_b, FWD_WB);
        // both MEM and WB write $3: MEM wins
        id_alu(3, 0, 0); tick();
        id_alu(3, 0, 0); tick();
        id_alu(10, 3, 3); tick();
        chk("fw_prec_a", hz_bus.fwd_a, FWD_MEM);
        chk("fw_prec_b", hz_bus.fwd_b, FWD_MEM);
        // writes to $0 never forward
        id_alu(0, 0, 0); tick();
        id_alu(0, 0, 0); tick();
        id_alu(10, 0, 0); tick();
        chk("fw_zero_a", hz_bus.fwd_a, FWD_RF);
        chk("fw_zero_b", hz_bus.fwd_b, FWD_RF);

        // branch taken with a simultaneous load-use hazard
        id_lw(8, 1); tick();
        id_alu(9, 8, 2);
        hz_bus.ex_branch_taken = 1'b1;
        #1;
        chk("br_fl", fl(), 3'b110);
        chk("br_en", en(), 4'b1111);
        tick();
        hz_bus.ex_branch_taken = 1'b0;
        #1;
        chk("br_state", hz_bus.state, ST_RUN);
        chk("br_en1", en(), 4'b1111);

        // jr $31 behind lw $31: two stall cycles then a one-cycle IF/ID flush
        id_lw(31, 1); tick();
        id_jr(31);
        #1;
        chk("jr_en0", en(), 4'b0011);
        chk("jr_fl0", fl(), 3'b010);
        tick();
        chk("jr_en1", en(), 4'b0011);
        chk("jr_fl1", fl(), 3'b010);
        chk("jr_state1", hz_bus.state, ST_STALL);
        tick();
        chk("jr_en2", en(), 4'b1111);
        chk("jr_fl2", fl(), 3'b100);
        chk("jr_state2", hz_bus.state, ST_STALL);
        tick();
        id_nop();
        #1;
        chk("jr_fl3", fl(), 3'b000);
        chk("jr_state3", hz_bus.state, ST_RUN);

        // sw in MEM waits 3 cycles; X($4) in WB, Y($6, reads $4) in EX
        id_alu(4, 0, 0); tick();
        id_sw(1, 2); tick();
        id_alu(6, 4, 0); tick();
        hz_bus.mem_ready       = 1'b0;
        hz_bus.ex_branch_taken = 1'b1;
        id_alu(11, 6, 0);
        #1;
        chk("mw_en0", en(), 4'b0000);
        chk("mw_fl0", fl(), 3'b001);
        chk("mw_fwd0", hz_bus.fwd_a, FWD_WB);
        tick();
        chk("mw_en1", en(), 4'b0000);
        chk("mw_fwd1", hz_bus.fwd_a, FWD_RF);
        chk("mw_state1", hz_bus.state, ST_MEM_WAIT);
        tick();
        chk("mw_en2", en(), 4'b0000);
        chk("mw_fl2", fl(), 3'b001);
        tick();
        hz_bus.mem_ready       = 1'b1;
        hz_bus.ex_branch_taken = 1'b0;
        #1;
        chk("mw_en3", en(), 4'b1111);
        chk("mw_state3", hz_bus.state, ST_MEM_WAIT);
        tick();
        chk("mw_state4", hz_bus.state, ST_RUN);
        chk("mw_held", hz_bus.fwd_a, FWD_MEM);

        // timeout: 16 consecutive wait cycles set mem_err
        id_sw(1, 2); tick();
        id_nop(); tick();
        hz_bus.mem_ready = 1'b0;
        repeat (15) tick();
        chk("to_15", hz_bus.mem_err, 0);
        tick();
        chk("to_16", hz_bus.mem_err, 1);
        tick();
        chk("to_17", hz_bus.mem_err, 1);
        chk("to_state", hz_bus.state, ST_MEM_WAIT);
        hz_bus.mem_ready = 1'b1;
        tick();
        chk("to_sticky", hz_bus.mem_err, 1);
        chk("to_run", hz_bus.state, ST_RUN);

        // async reset during MEM_WAIT
        id_sw(1, 2); tick();
        id_nop(); tick();
        hz_bus.mem_ready = 1'b0;
        tick(); tick();
        chk("ar_pre_state", hz_bus.state, ST_MEM_WAIT);
        chk("ar_pre_err", hz_bus.mem_err, 1);
        chk("ar_pre_en", en(), 4'b0000);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_state", hz_bus.state, ST_RUN);
        chk("ar_err", hz_bus.mem_err, 0);
        chk("ar_en", en(), 4'b1111);
        chk("ar_fl", fl(), 3'b000);
        chk("ar_fwd", {hz_bus.fwd_a, hz_bus.fwd_b}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        hz_bus.mem_ready = 1'b1;
        tick();
        chk("ar_post_state", hz_bus.state, ST_RUN);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
